// File: rtl/piso_bit_serializer_pkg.sv
// Shared types and constants for the parallel-in/serial-out bit serializer.
package piso_bit_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } piso_state_e;

    localparam int GAP_W = 4;

    // Terminal value of the inter-word gap counter for a given gap length.
    function automatic logic [GAP_W-1:0] gap_terminal(input int gap);
        gap_terminal = GAP_W'(gap - 1);
    endfunction

endpackage

// File: rtl/piso_bit_serializer_hold.sv
// One-entry holding buffer in front of the shifter; din_ready is a flop so the
// upstream handshake never sees a combinational path from din_valid.
module piso_hold_buf
    import piso_bit_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             ready
);

    logic [WIDTH-1:0] data_r;
    logic             full_r;
    logic             ready_r;
    logic [WIDTH-1:0] data_nxt_s;
    logic             full_nxt_s;

    // Next buffer contents: a push wins over a simultaneous pop and keeps the entry full.
    always_comb begin
        data_nxt_s = data_r;
        full_nxt_s = full_r;
        if (push) begin
            data_nxt_s = din;
            full_nxt_s = 1'b1;
        end else if (pop) begin
            data_nxt_s = data_r;
            full_nxt_s = 1'b0;
        end else begin
            data_nxt_s = data_r;
            full_nxt_s = full_r;
        end
    end

    // Buffer state and registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {WIDTH{1'b0}};
            full_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            data_r  <= data_nxt_s;
            full_r  <= full_nxt_s;
            ready_r <= ~full_nxt_s;
        end
    end

    assign dout  = data_r;
    assign full  = full_r;
    assign ready = ready_r;

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out serializer feeding the sreg sequence detector: one bit
// per clock, optional idle gap between words, all outputs registered.
module piso_bit_serializer
    import piso_bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int CNT_W     = $clog2(WIDTH);
    localparam bit MSB_FIRST_B = (MSB_FIRST != 0);
    localparam bit HAS_GAP   = (GAP != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = gap_terminal(GAP);

    piso_state_e      state_r;
    piso_state_e      state_nxt_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [GAP_W-1:0] gap_r;
    logic [GAP_W-1:0] gap_nxt_s;
    logic             load_s;
    logic             push_s;
    logic             last_bit_s;
    logic             gap_done_s;
    logic             cur_bit_s;
    logic             hold_full_s;
    logic             hold_ready_s;
    logic [WIDTH-1:0] hold_data_s;
    logic             sout_r;
    logic             sout_valid_r;
    logic             sof_r;
    logic             eof_r;
    logic             busy_r;

    assign push_s     = din_valid & hold_ready_s;
    assign last_bit_s = (cnt_r == CNT_LAST);
    assign gap_done_s = (gap_r == GAP_LAST);
    assign cur_bit_s  = MSB_FIRST_B ? shift_r[WIDTH-1] : shift_r[0];

    piso_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (load_s),
        .din   (din),
        .dout  (hold_data_s),
        .full  (hold_full_s),
        .ready (hold_ready_s)
    );

    // Next-state and load decision; load only ever depends on registered state.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hold_full_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!last_bit_s) begin
                    state_nxt_s = ST_SHIFT;
                end else if (HAS_GAP) begin
                    state_nxt_s = ST_GAP;
                end else if (hold_full_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (!gap_done_s) begin
                    state_nxt_s = ST_GAP;
                end else if (hold_full_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                load_s      = 1'b0;
            end
        endcase
    end

    // Shifter, bit counter and gap counter updates.
    always_comb begin
        shift_nxt_s = shift_r;
        cnt_nxt_s   = cnt_r;
        gap_nxt_s   = {GAP_W{1'b0}};
        if (load_s) begin
            shift_nxt_s = hold_data_s;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (state_r == ST_SHIFT) begin
            if (MSB_FIRST_B) begin
                shift_nxt_s = {shift_r[WIDTH-2:0], 1'b0};
            end else begin
                shift_nxt_s = {1'b0, shift_r[WIDTH-1:1]};
            end
            cnt_nxt_s = last_bit_s ? cnt_r : (cnt_r + CNT_W'(1));
        end else begin
            shift_nxt_s = shift_r;
            cnt_nxt_s   = cnt_r;
        end
        if ((state_r == ST_GAP) && !gap_done_s) begin
            gap_nxt_s = gap_r + GAP_W'(1);
        end else begin
            gap_nxt_s = {GAP_W{1'b0}};
        end
    end

    // Datapath and FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            shift_r <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            gap_r   <= {GAP_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            shift_r <= shift_nxt_s;
            cnt_r   <= cnt_nxt_s;
            gap_r   <= gap_nxt_s;
        end
    end

    // Output stage: the bit currently at the shifter head is presented one clock later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
            sof_r        <= 1'b0;
            eof_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            sout_r       <= (state_r == ST_SHIFT) & cur_bit_s;
            sout_valid_r <= (state_r == ST_SHIFT);
            sof_r        <= (state_r == ST_SHIFT) & (cnt_r == {CNT_W{1'b0}});
            eof_r        <= (state_r == ST_SHIFT) & last_bit_s;
            busy_r       <= hold_full_s | (state_r != ST_IDLE);
        end
    end

    assign din_ready  = hold_ready_s;
    assign sout       = sout_r;
    assign sout_valid = sout_valid_r;
    assign sof        = sof_r;
    assign eof        = eof_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench for piso_bit_serializer: three instances (default, GAP=2,
// LSB-first) with a per-instance scoreboard of expected serial bits.
module tb_piso_bit_serializer;

    typedef struct packed {
        logic b;
        logic s;
        logic e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din_v [3];
    logic [2:0] dv_v = 3'b000;
    wire  [2:0] rdy, so, sv, sf, ef, bz;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int total = 0;
    int passed = 0;
    int fails = 0;
    int cur_run = 0;
    int last_run = 0;
    int acc_cnt = 0;
    int eof_cnt0 = 0;

    always #5 clk = ~clk;

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .din(din_v[0]), .din_valid(dv_v[0]), .din_ready(rdy[0]),
        .sout(so[0]), .sout_valid(sv[0]), .sof(sf[0]), .eof(ef[0]), .busy(bz[0]));

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(2)) u_gap (
        .clk(clk), .rst_n(rst_n), .din(din_v[1]), .din_valid(dv_v[1]), .din_ready(rdy[1]),
        .sout(so[1]), .sout_valid(sv[1]), .sof(sf[1]), .eof(ef[1]), .busy(bz[1]));

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .din(din_v[2]), .din_valid(dv_v[2]), .din_ready(rdy[2]),
        .sout(so[2]), .sout_valid(sv[2]), .sof(sf[2]), .eof(ef[2]), .busy(bz[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int qsize(input int w);
        case (w)
            0:       qsize = q0.size();
            1:       qsize = q1.size();
            default: qsize = q2.size();
        endcase
    endfunction

    task automatic qpush(input int w, input exp_t e);
        case (w)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(input int w, output exp_t e);
        case (w)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    // Expected serial stream for one word, in emission order.
    task automatic push_exp(input int w, input logic [7:0] word);
        exp_t e;
        int   idx;
        for (int i = 0; i < 8; i++) begin
            idx = (w == 2) ? i : (7 - i);
            e.b = word[idx];
            e.s = (i == 0);
            e.e = (i == 7);
            qpush(w, e);
        end
    endtask

    // Offer one word starting at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input int w, input logic [7:0] word);
        logic ok;
        ok = 1'b0;
        din_v[w] = word;
        dv_v[w]  = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            if (rdy[w]) begin
                push_exp(w, word);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        chk($sformatf("accept%0d_%02h", w, word), 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input int w);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            #1;
            if (qsize(w) == 0 && !bz[w]) done = 1'b1;
        end
        chk($sformatf("idle%0d", w), 32'(done), 32'd1);
    endtask

    task automatic mon(input int w);
        exp_t e;
        if (sv[w]) begin
            total++;
            assert (qsize(w) != 0) passed++;
            else begin
                fails++;
                $error("FAIL unexpected_bit%0d: sout_valid=1 with no word expected", w);
            end
            if (qsize(w) != 0) begin
                qpop(w, e);
                chk($sformatf("bit%0d", w), 32'({so[w], sf[w], ef[w]}), 32'({e.b, e.s, e.e}));
            end
        end else begin
            chk($sformatf("idle_out%0d", w), 32'({so[w], sf[w], ef[w]}), 32'd0);
        end
    endtask

    // Scoreboard comparison of every instance on each falling edge.
    always @(negedge clk) begin
        for (int w = 0; w < 3; w++) mon(w);
    end

    // Length of the most recent contiguous sout_valid run on the default instance.
    always @(negedge clk) begin
        if (sv[0]) cur_run++;
        else begin
            if (cur_run != 0) last_run = cur_run;
            cur_run = 0;
        end
        if (ef[0]) eof_cnt0++;
    end

    // Independent accept counter for the default instance.
    always @(posedge clk) begin
        if (rst_n && dv_v[0] && rdy[0]) acc_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int e0;
        logic seen;
        for (int w = 0; w < 3; w++) din_v[w] = 8'h00;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++)
            chk($sformatf("reset%0d", w), 32'({rdy[w], sv[w], so[w], sf[w], ef[w], bz[w]}), 32'b100000);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single word, MSB first, two-clock latency
        send(0, 8'b10011001);
        dv_v[0] = 1'b0;
        @(negedge clk);
        chk("t1_not_yet", 32'(sv[0]), 32'd0);
        @(negedge clk);
        chk("t1_first_bit", 32'({sv[0], sf[0], so[0]}), 32'd7);
        wait_idle(0);

        // 2: back-to-back words, contiguous output
        send(0, 8'hA5);
        chk("t2_rdy_low", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        chk("t2_rdy_back", 32'(rdy[0]), 32'd1);
        send(0, 8'h3C);
        dv_v[0] = 1'b0;
        wait_idle(0);
        chk("t2_run_len", 32'(last_run), 32'd16);

        // 3: GAP=2 between words
        send(1, 8'hFF);
        send(1, 8'h00);
        dv_v[1] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ef[1]) seen = 1'b1;
        end
        chk("t3_eof_seen", 32'(seen), 32'd1);
        @(negedge clk);
        chk("t3_gap1", 32'({sv[1], so[1]}), 32'd0);
        @(negedge clk);
        chk("t3_gap2", 32'({sv[1], so[1]}), 32'd0);
        @(negedge clk);
        chk("t3_sof_after_gap", 32'({sv[1], sf[1], so[1]}), 32'b110);
        wait_idle(1);

        // 4: LSB first
        send(2, 8'h01);
        dv_v[2] = 1'b0;
        wait_idle(2);

        // 5: reset during bit 3 of 8'hF0 with 8'h0F held
        send(0, 8'hF0);
        send(0, 8'h0F);
        dv_v[0] = 1'b0;
        chk("t5_hold_full", 32'(rdy[0]), 32'd0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        q0.delete();
        #1;
        chk("t5_reset_outs", 32'({rdy[0], sv[0], so[0], sf[0], ef[0], bz[0]}), 32'b100000);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            seen = seen | sv[0] | bz[0];
        end
        chk("t5_no_emit", 32'(seen), 32'd0);

        // 6: din_valid held high over three words
        a0 = acc_cnt;
        e0 = eof_cnt0;
        send(0, 8'h11);
        send(0, 8'h22);
        send(0, 8'h33);
        dv_v[0] = 1'b0;
        for (int k = 0; k < 80 && (eof_cnt0 - e0) < 3; k++) begin
            @(negedge clk);
            #1;
        end
        chk("t6_eofs", 32'(eof_cnt0 - e0), 32'd3);
        chk("t6_busy_at_eof", 32'(bz[0]), 32'd1);
        @(negedge clk);
        chk("t6_busy_fall", 32'(bz[0]), 32'd0);
        chk("t6_accepts", 32'(acc_cnt - a0), 32'd3);
        repeat (3) @(negedge clk);
        #1;
        chk("queues_empty", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
